simplify_arbiter: RTL and testbench
===================================

SIMPLIFY_ARBITER -- requirements
Module: simplify_arbiter

Interface
REQ-001 SHALL have parameter INT_WIDTH, default 64: operand width of numerator and denominator.
REQ-002 SHALL have parameter THRESH_INDEX, default 30: passed unchanged to the shared simplify unit.
REQ-003 SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-004 SHALL have parameter SIMP_LATENCY, default 1: clock edges from simp_in_* valid to simp_out_* valid.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port en, input, 1: when low, no new grant is issued; the in-flight pipeline still advances.
REQ-008 SHALL have port req_valid, input, NUM_REQ: per-requester request valid.
REQ-009 SHALL have port req_ready, output, NUM_REQ: per-requester accept, one-hot or zero.
REQ-010 SHALL have port req_num, input, NUM_REQ*INT_WIDTH: flattened numerators, requester i at slice i.
REQ-011 SHALL have port req_den, input, NUM_REQ*INT_WIDTH: flattened denominators.
REQ-012 SHALL have port simp_in_num and simp_in_den, output, INT_WIDTH each: operands to the shared simplify unit.
REQ-013 SHALL have port simp_out_num, input, INT_WIDTH-1: reduced numerator from the simplify unit.
REQ-014 SHALL have port simp_out_den, input, INT_WIDTH: reduced denominator from the simplify unit.
REQ-015 SHALL have port rsp_valid, output, 1: single-cycle response strobe.
REQ-016 SHALL have port rsp_id, output, clog2(NUM_REQ): requester index of the response.
REQ-017 SHALL have port rsp_num, output, INT_WIDTH-1, and port rsp_den, output, INT_WIDTH: the response result.
REQ-018 SHALL have port rsp_err, output, 1: the request had a zero denominator.
REQ-019 SHALL have port inflight, output, clog2(SIMP_LATENCY+3): accepted requests not yet answered.

Function
REQ-020 SHALL grant round-robin: at most one req_ready per cycle, only to a requester with req_valid high, and only when en is high.
REQ-021 SHALL, after a grant to index g, make g+1 (mod NUM_REQ) the highest priority; the pointer SHALL hold when there is no grant.
REQ-022 SHALL drive req_ready combinationally from req_valid, en and the pointer; a request is accepted only in a cycle where valid and ready are both high.
REQ-023 SHALL load the accepted operands into the issue register at the end of accept cycle 0, driving simp_in_* in cycle 1; simp_in_* SHALL hold their last value when idle.
REQ-024 SHALL carry a tag {valid, id, err} through a shift register of depth SIMP_LATENCY+1, aligned with the simplify output.
REQ-025 SHALL register the response so that rsp_valid is high for exactly one cycle, cycle 2+SIMP_LATENCY (cycle 3 at default), with rsp_id and rsp_err taken from the tag.
REQ-026 SHALL still issue a request with den==0 to the simplify unit, set rsp_err=1 and force rsp_num=0 and rsp_den=0.
REQ-027 SHALL sustain one accept per cycle back-to-back; responses SHALL return in accept order with no gaps.
REQ-028 SHALL update inflight each cycle as +1 on accept and -1 on response; accept and response in the same cycle leave it unchanged.
REQ-029 SHALL hold rsp_num, rsp_den, rsp_id and rsp_err at their last value while rsp_valid is low.

Reset
REQ-030 SHALL, while rst is high at a clock edge: clear req_ready, rsp_valid, rsp_err and all tag valids; set rsp_id, rsp_num, rsp_den, simp_in_num, simp_in_den and inflight to 0; and set the round-robin pointer to 0.
REQ-031 SHALL drop requests in flight when reset is asserted mid-operation: no rsp_valid for them after rst is released.
REQ-032 SHALL hold req_ready low in every cycle that rst is high.

Structure
REQ-033 SHALL take the default INT_WIDTH and the tag record type (valid, id, err) from the shared package rat_pkg.
REQ-034 SHALL put the round-robin arbiter in the sub-module rr_arbiter (NUM_REQ parameter; ports req, en, grant one-hot, pointer update), instantiated once.
REQ-035 SHALL NOT instantiate the simplify unit itself; the top level connects simp_* to a single shared simplify instance.

Verification
REQ-036 SHALL cover: single requester 1, num=6, den=4, with a default-latency model → rsp_valid in cycle 3, rsp_id=1, rsp_err=0, result equal to the model output.
REQ-037 SHALL cover: all four req_valid held high for 8 cycles → grant order 0,1,2,3,0,1,2,3, eight back-to-back responses in the same order.
REQ-038 SHALL cover: requester 2 with den=0 → rsp_err=1, rsp_num=0, rsp_den=0, rsp_id=2, and ordering kept relative to neighbours.
REQ-039 SHALL cover: en low for 3 cycles with requests pending → no req_ready during those cycles; earlier in-flight requests still respond; the pointer is unchanged.
REQ-040 SHALL cover: rst pulsed for 1 cycle with inflight=2 → no responses afterwards, inflight=0, and the next grant goes to requester 0.
REQ-041 SHALL cover: SIMP_LATENCY=3 build with back-to-back accepts → responses in cycle 5 after each accept, inflight peaking at 5.

Source files
------------

// File: rtl/rat_pkg.sv
// rat_pkg: shared default operand width and the {valid, id, err} tag record carried beside the simplify pipeline
package rat_pkg;
  localparam int INT_WIDTH_DEF = 64;
  localparam int ID_W = 3;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } tag_t;
endpackage

// File: rtl/simplify_arbiter_if.sv
// simplify_arbiter_if: request/ready bus, shared simplify operand/result bus, response bus and inflight count; slave=arbiter, master=environment
interface simplify_arbiter_if import rat_pkg::*; #(
  parameter int INT_WIDTH = INT_WIDTH_DEF,
  parameter int NUM_REQ = 4,
  parameter int SIMP_LATENCY = 1
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int IFW = $clog2(SIMP_LATENCY + 3);
  logic                         en;
  logic [NUM_REQ-1:0]           req_valid, req_ready;
  logic [NUM_REQ*INT_WIDTH-1:0] req_num, req_den;
  logic [INT_WIDTH-1:0]         simp_in_num, simp_in_den;
  logic [INT_WIDTH-2:0]         simp_out_num;
  logic [INT_WIDTH-1:0]         simp_out_den;
  logic                         rsp_valid, rsp_err;
  logic [IDW-1:0]               rsp_id;
  logic [INT_WIDTH-2:0]         rsp_num;
  logic [INT_WIDTH-1:0]         rsp_den;
  logic [IFW-1:0]               inflight;
  modport master (
    output en, req_valid, req_num, req_den, simp_out_num, simp_out_den,
    input  req_ready, simp_in_num, simp_in_den, rsp_valid, rsp_id, rsp_num, rsp_den, rsp_err, inflight
  );
  modport slave (
    input  en, req_valid, req_num, req_den, simp_out_num, simp_out_den,
    output req_ready, simp_in_num, simp_in_den, rsp_valid, rsp_id, rsp_num, rsp_den, rsp_err, inflight
  );
endinterface

// File: rtl/simplify_arbiter_rr.sv
// rr_arbiter: round-robin grant (clk, rst, req_i, en_i -> one-hot grant_o, index gid_o); pointer moves past each winner
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic                       en_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] gid_o
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [IDW-1:0] ptr_q, ptr_d, j;
  logic hit;
  always_comb begin
    gid_o = '0;
    hit = 1'b0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (en_i && req_i[j]) begin
        gid_o = j;
        hit = 1'b1;
      end
    end
    grant_o = NUM_REQ'(hit) << gid_o;
    ptr_d = !hit ? ptr_q : gid_o == IDW'(NUM_REQ - 1) ? '0 : gid_o + 1'b1;
  end
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
endmodule

// File: rtl/simplify_arbiter.sv
// simplify_arbiter: shares one simplify unit among NUM_REQ requesters (clk, rst, bus: req_*/en in, simp_* to/from unit, rsp_*/inflight out)
module simplify_arbiter import rat_pkg::*; #(
  parameter int INT_WIDTH = INT_WIDTH_DEF,
  parameter int THRESH_INDEX = 30,
  parameter int NUM_REQ = 4,
  parameter int SIMP_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  simplify_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int IFW = $clog2(SIMP_LATENCY + 3);
  if (NUM_REQ < 2 || NUM_REQ > 8 || THRESH_INDEX < 0) begin : g_bad_param
    $error("simplify_arbiter: unsupported parameter set");
  end
  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       gid;
  logic                 acc;
  logic [INT_WIDTH-1:0] sel_num, sel_den, num_q, den_q;
  tag_t                 tag_d;
  tag_t                 tag_q [SIMP_LATENCY+1];
  logic                 rsp_valid_q, rsp_err_q;
  logic [IDW-1:0]       rsp_id_q;
  logic [INT_WIDTH-2:0] rsp_num_q;
  logic [INT_WIDTH-1:0] rsp_den_q;
  logic [IFW-1:0]       inflight_q, inflight_d;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req_i(bus.req_valid),
    .en_i(bus.en & ~rst),
    .grant_o(grant),
    .gid_o(gid)
  );
  always_comb begin
    sel_num = '0;
    sel_den = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        sel_num = bus.req_num[i*INT_WIDTH +: INT_WIDTH];
        sel_den = bus.req_den[i*INT_WIDTH +: INT_WIDTH];
      end
    acc = |grant;
    tag_d = {acc, ID_W'(gid), ~|sel_den};
    inflight_d = inflight_q + IFW'(acc) - IFW'(rsp_valid_q);
  end
  // Tag stage SIMP_LATENCY lines up with simp_out_*; the response register captures both together.
  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= '0;
      den_q <= '0;
      tag_q <= '{default: '0};
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_num_q <= '0;
      rsp_den_q <= '0;
      inflight_q <= '0;
    end else begin
      if (acc) begin
        num_q <= sel_num;
        den_q <= sel_den;
      end
      tag_q[0] <= tag_d;
      for (int i = 1; i <= SIMP_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid_q <= tag_q[SIMP_LATENCY].valid;
      if (tag_q[SIMP_LATENCY].valid) begin
        rsp_id_q <= IDW'(tag_q[SIMP_LATENCY].id);
        rsp_err_q <= tag_q[SIMP_LATENCY].err;
        rsp_num_q <= tag_q[SIMP_LATENCY].err ? '0 : bus.simp_out_num;
        rsp_den_q <= tag_q[SIMP_LATENCY].err ? '0 : bus.simp_out_den;
      end
      inflight_q <= inflight_d;
    end
  end
  assign bus.req_ready = grant;
  assign bus.simp_in_num = num_q;
  assign bus.simp_in_den = den_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id = rsp_id_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.rsp_num = rsp_num_q;
  assign bus.rsp_den = rsp_den_q;
  assign bus.inflight = inflight_q;
endmodule

// File: tb/tb_simplify_arbiter.sv
// tb_simplify_arbiter: directed scoreboard bench driving a latency-1 and a latency-3 arbiter with identical stimulus
module tb_simplify_arbiter;
  typedef struct {
    int          id;
    logic [62:0] num;
    logic [63:0] den;
    logic        err;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  logic rst, en;
  logic [3:0] rv;
  logic [255:0] rn, rd;
  int cyc = 0, checks = 0, errors = 0, pk1 = 0, pk3 = 0;
  exp_t sb1[$], sb3[$];
  logic [126:0] m1;
  logic [126:0] m3 [3];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  simplify_arbiter_if #(.INT_WIDTH(64), .NUM_REQ(4), .SIMP_LATENCY(1)) b1 ();
  simplify_arbiter_if #(.INT_WIDTH(64), .NUM_REQ(4), .SIMP_LATENCY(3)) b3 ();
  simplify_arbiter #(.INT_WIDTH(64), .THRESH_INDEX(30), .NUM_REQ(4), .SIMP_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  simplify_arbiter #(.INT_WIDTH(64), .THRESH_INDEX(30), .NUM_REQ(4), .SIMP_LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));
  assign b1.en = en;
  assign b3.en = en;
  assign b1.req_valid = rv;
  assign b3.req_valid = rv;
  assign b1.req_num = rn;
  assign b3.req_num = rn;
  assign b1.req_den = rd;
  assign b3.req_den = rd;
  assign b1.simp_out_num = m1[126:64];
  assign b1.simp_out_den = m1[63:0];
  assign b3.simp_out_num = m3[2][126:64];
  assign b3.simp_out_den = m3[2][63:0];
  function automatic logic [126:0] f(input logic [63:0] n, input logic [63:0] d);
    logic [63:0] a = n, b = d, t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    if (a == 0) a = 1;
    return {63'(n / a), d / a};
  endfunction
  always @(posedge clk) begin
    m1 <= f(b1.simp_in_num, b1.simp_in_den);
    m3[0] <= f(b3.simp_in_num, b3.simp_in_den);
    m3[1] <= m3[0];
    m3[2] <= m3[1];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [63:0] n, input logic [63:0] d);
    rn[i*64 +: 64] = n;
    rd[i*64 +: 64] = d;
  endtask
  task automatic mon(input bit u, input int lat, input logic [3:0] rdy, input logic v, input logic [1:0] id,
                     input logic [62:0] n, input logic [63:0] d, input logic e);
    exp_t x;
    int sz;
    sz = u ? sb3.size() : sb1.size();
    chk(u ? "ready_onehot_l3" : "ready_onehot_l1", 64'($countones(rdy) <= 1 && (rdy & ~rv) == 0), 1);
    if (v) begin
      chk(u ? "rsp_expected_l3" : "rsp_expected_l1", 64'(sz > 0), 1);
      if (sz > 0) begin
        if (u) x = sb3.pop_front();
        else x = sb1.pop_front();
        chk("rsp_id", 64'(id), 64'(x.id));
        chk("rsp_num", 64'(n), 64'(x.num));
        chk("rsp_den", d, x.den);
        chk("rsp_err", 64'(e), 64'(x.err));
        chk("rsp_cycle", 64'(cyc), 64'(x.due));
      end
    end
    if (rst) begin
      if (u) sb3.delete();
      else sb1.delete();
    end else
      for (int i = 0; i < 4; i++)
        if (rdy[i] && rv[i]) begin
          x.id = i;
          x.err = rd[i*64 +: 64] == 0;
          {x.num, x.den} = x.err ? 127'(0) : f(rn[i*64 +: 64], rd[i*64 +: 64]);
          x.due = cyc + 2 + lat;
          if (u) sb3.push_back(x);
          else sb1.push_back(x);
        end
  endtask
  always @(negedge clk) begin
    mon(1'b0, 1, b1.req_ready, b1.rsp_valid, b1.rsp_id, b1.rsp_num, b1.rsp_den, b1.rsp_err);
    mon(1'b1, 3, b3.req_ready, b3.rsp_valid, b3.rsp_id, b3.rsp_num, b3.rsp_den, b3.rsp_err);
    if (int'(b1.inflight) > pk1) pk1 = int'(b1.inflight);
    if (int'(b3.inflight) > pk3) pk3 = int'(b3.inflight);
  end
  initial begin
    rst = 1'b1;
    en = 1'b1;
    rv = '0;
    rn = '0;
    rd = '0;
    tick();
    rv = 4'hf;
    @(negedge clk);
    chk("rst_ready", 64'(b1.req_ready), 0);
    chk("rst_rsp_valid", 64'(b1.rsp_valid), 0);
    chk("rst_inflight", 64'(b1.inflight), 0);
    chk("rst_simp_in_num", b1.simp_in_num, 0);
    chk("rst_rsp_den", b1.rsp_den, 0);
    chk("rst_rsp_id", 64'(b1.rsp_id), 0);
    for (int i = 0; i < 4; i++) set_req(i, 64'(12 * (i + 1)), i == 2 ? 64'd0 : 64'(8 + 4 * i));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_order_l1", 64'(b1.req_ready), 64'(1 << (k % 4)));
      chk("rr_order_l3", 64'(b3.req_ready), 64'(1 << (k % 4)));
      tick();
    end
    rv = '0;
    repeat (6) tick();
    rv = 4'b0010;
    set_req(1, 6, 4);
    @(negedge clk);
    chk("single_ready", 64'(b1.req_ready), 64'b0010);
    tick();
    rv = '0;
    tick();
    tick();
    @(negedge clk);
    chk("single_rsp_valid", 64'(b1.rsp_valid), 1);
    chk("single_rsp_id", 64'(b1.rsp_id), 1);
    chk("single_rsp_num", 64'(b1.rsp_num), 3);
    chk("single_rsp_den", b1.rsp_den, 2);
    chk("single_rsp_err", 64'(b1.rsp_err), 0);
    tick();
    set_req(2, 30, 10);
    rv = 4'b0100;
    @(negedge clk);
    chk("pre_en_ready", 64'(b1.req_ready), 64'b0100);
    tick();
    en = 1'b0;
    rv = 4'hf;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("en_low_ready_l1", 64'(b1.req_ready), 0);
      chk("en_low_ready_l3", 64'(b3.req_ready), 0);
      chk("en_low_rsp", 64'(b1.rsp_valid), 64'(j == 2));
      tick();
    end
    en = 1'b1;
    @(negedge clk);
    chk("en_resume_ptr", 64'(b1.req_ready), 64'b1000);
    tick();
    rv = 4'b0010;
    @(negedge clk);
    chk("pre_rst_ready", 64'(b1.req_ready), 64'b0010);
    tick();
    rv = '0;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_inflight_l1", 64'(b1.inflight), 2);
    chk("pre_rst_inflight_l3", 64'(b3.inflight), 2);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_inflight_l1", 64'(b1.inflight), 0);
    chk("post_rst_inflight_l3", 64'(b3.inflight), 0);
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("dropped_l1", 64'(b1.rsp_valid), 0);
      chk("dropped_l3", 64'(b3.rsp_valid), 0);
      tick();
    end
    rv = 4'hf;
    pk1 = 0;
    pk3 = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("post_rst_order", 64'(b3.req_ready), 64'(1 << (k % 4)));
      tick();
    end
    rv = '0;
    repeat (10) tick();
    chk("peak_inflight_l1", 64'(pk1), 3);
    chk("peak_inflight_l3", 64'(pk3), 5);
    chk("drained_l1", 64'(sb1.size()), 0);
    chk("drained_l3", 64'(sb3.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
